// File: rtl/bcd_add_seq_pkg.sv
// Shared types and constants for the sequential 4-digit BCD adder.
package bcd_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    localparam int NDIG  = 4;
    localparam int DIG_W = 4;
    localparam int IDX_W = $clog2(NDIG);

    localparam logic [DIG_W-1:0] BCD_MAX   = DIG_W'(9);
    localparam logic [DIG_W:0]   BCD_RADIX = {1'b0, BCD_MAX} + 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NDIG - 1);

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal carry and invalid-digit flag.
module bcd_digit_add
    import bcd_add_seq_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] d,
    output logic       co,
    output logic       bad
);

    logic [DIG_W:0] t;

    always_comb begin
        t   = {1'b0, x} + {1'b0, y} + {{DIG_W{1'b0}}, ci};
        // NOTE: every output is given a default before the branch so no path infers a latch.
        d   = t[DIG_W-1:0];
        co  = 1'b0;
        if (t >= BCD_RADIX) begin
            // Invalid digits can push t up to 31; the correction wraps mod 16.
            d  = DIG_W'(t - BCD_RADIX);
            co = 1'b1;
        end
        bad = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule

// File: rtl/bcd_add_seq.sv
// Sequential 4-digit packed-BCD adder: one shared digit adder, one digit per clock.
module bcd_add_seq
    import bcd_add_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        err
);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [NDIG*DIG_W-1:0]  opa;
    logic [NDIG*DIG_W-1:0]  opb;
    logic                   cin_q;
    logic                   carry;

    logic [DIG_W-1:0]       dig_x;
    logic [DIG_W-1:0]       dig_y;
    logic                   dig_ci;
    logic [DIG_W-1:0]       dig_d;
    logic                   dig_co;
    logic                   dig_bad;

    assign dig_x  = opa[idx*DIG_W +: DIG_W];
    assign dig_y  = opb[idx*DIG_W +: DIG_W];
    assign dig_ci = (idx == '0) ? cin_q : carry;

    bcd_digit_add u_digit (
        .x   (dig_x),
        .y   (dig_y),
        .ci  (dig_ci),
        .d   (dig_d),
        .co  (dig_co),
        .bad (dig_bad)
    );

    // NOTE: operand registers have no reset; they are only read after a start has reloaded them.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && start) begin
            opa   <= a;
            opb   <= b;
            cin_q <= cin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ADD;
                        idx   <= '0;
                        busy  <= 1'b1;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ADD: begin
                    sum[idx*DIG_W +: DIG_W] <= dig_d;
                    carry <= dig_co;
                    idx   <= idx + 1'b1;
                    if (dig_bad) begin
                        err <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        cout  <= dig_co;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_add_seq.sv
// Scoreboard bench for bcd_add_seq: decimal reference model, directed corner cases, random operands.
module tb_bcd_add_seq;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t cur;
    exp_t held;
    bit   hold_pending = 1'b0;

    bcd_add_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Valid operands: add as decimal integers. Invalid digits: apply the per-digit rule.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        exp_t r;
        bit   ok = 1'b1;
        int   da = 0;
        int   db = 0;
        int   s;
        int   c;
        for (int d = 3; d >= 0; d--) begin
            int x = int'((av >> (4 * d)) & 16'hF);
            int y = int'((bv >> (4 * d)) & 16'hF);
            if (x > 9 || y > 9) ok = 1'b0;
            da = da * 10 + x;
            db = db * 10 + y;
        end
        r.sum      = '0;
        r.err      = !ok;
        r.done_cyc = 0;
        if (ok) begin
            s      = da + db + int'(cv);
            r.cout = (s >= 10000);
            s      = s % 10000;
            for (int d = 0; d < 4; d++) begin
                r.sum[d*4 +: 4] = 4'(s % 10);
                s = s / 10;
            end
        end else begin
            c = int'(cv);
            for (int d = 0; d < 4; d++) begin
                int t = int'((av >> (4 * d)) & 16'hF) + int'((bv >> (4 * d)) & 16'hF) + c;
                if (t < 10) begin
                    r.sum[d*4 +: 4] = 4'(t);
                    c = 0;
                end else begin
                    r.sum[d*4 +: 4] = 4'((t - 10) % 16);
                    c = 1;
                end
            end
            r.cout = c[0];
        end
        return r;
    endfunction

    // Issue one operation at a negedge once the DUT is idle; operands are scrambled after acceptance.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv, input bit now);
        exp_t e;
        int   n = 0;
        if (!now) @(negedge clk);
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            check("idle_timeout", 32'(busy), 32'd0);
            return;
        end
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        e          = model(av, bv, cv);
        e.done_cyc = cyc + 5;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
    endtask

    always @(negedge clk) begin
        if (hold_pending) begin
            check("hold_sum",  32'(sum),  32'(held.sum));
            check("hold_cout", 32'(cout), 32'(held.cout));
            check("hold_err",  32'(err),  32'(held.err));
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
            hold_pending = 1'b0;
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("sum",      32'(sum),  32'(cur.sum));
                check("cout",     32'(cout), 32'(cur.cout));
                check("err",      32'(err),  32'(cur.err));
                check("done_cyc", 32'(cyc),  32'(cur.done_cyc));
                check("busy_in_done", 32'(busy), 32'd1);
                held         = cur;
                hold_pending = 1'b1;
            end
        end
    end

    initial begin
        logic [15:0] av;
        logic [15:0] bv;
        int          n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        rst = 1'b0;

        // Start on the very first edge after reset falls.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b1);
        start_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        start_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        start_op(16'h000A, 16'h0005, 1'b0, 1'b0);
        start_op(16'h0012, 16'h0034, 1'b0, 1'b0);
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        // Start pulses during ADD and DONE must be ignored.
        start_op(16'h0808, 16'h0191, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 16'h5555; b = 16'h4444; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        a = 16'h7777; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Reset in the second ADD cycle abandons the operation.
        start_op(16'h2468, 16'h1357, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err",  32'(err),  32'd0);
        rst = 1'b0;
        start_op(16'h0456, 16'h0789, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                for (int d = 0; d < 4; d++) begin
                    av[d*4 +: 4] = 4'($urandom_range(0, 9));
                    bv[d*4 +: 4] = 4'($urandom_range(0, 9));
                end
            end else begin
                av = 16'($urandom);
                bv = 16'($urandom);
            end
            start_op(av, bv, 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_add_seq.md
BCD_ADD_SEQ -- requirements
Module: bcd_add_seq

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-high.
REQ-002 SHALL expose the following ports, one per line, clock and reset first:
- clk  in  1  rising-edge system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request to begin an addition; sampled only in IDLE
- a  in  16  operand A, 4 packed BCD digits, a[3:0] = least significant digit
- b  in  16  operand B, same packing as a
- cin  in  1  carry into digit 0
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse, result valid
- sum  out  16  packed BCD result, same packing as a
- cout  out  1  decimal carry out of digit 3
- err  out  1  sticky flag: some operand digit was greater than 9

Function
REQ-003 SHALL implement three FSM states:
- IDLE -> ADD on an edge where start=1.
- ADD -> ADD while idx<3.
- ADD -> DONE on the edge that processes idx=3.
- DONE -> IDLE unconditionally.
REQ-004 On the edge where start is accepted, SHALL:
- latch a, b and cin into internal registers;
- set idx=0;
- clear sum, cout and err.
REQ-005 On each ADD edge, SHALL process digit idx as follows:
- t = A[idx] + B[idx] + c, where t is 5 bits wide;
- if t<10: digit=t, carry=0;
- else: digit=(t-10) mod 16, carry=1;
- write digit into sum[idx], store carry, then idx=idx+1.
REQ-006 c SHALL be the latched cin for idx=0 and the stored carry of the previous digit otherwise.
REQ-007 On the idx=3 edge, SHALL load cout with the digit-3 carry.
REQ-008 SHALL set err on any ADD edge where A[idx]>9 or B[idx]>9; the computation still follows REQ-005.
REQ-009 Latency: start is accepted at edge k; ADD edges are k+1 to k+4; done=1 during the cycle after edge k+4; DONE lasts exactly one cycle.
REQ-010 busy SHALL be 1 in ADD and DONE, and 0 in IDLE.
REQ-011 SHALL ignore start while busy=1, including in DONE; there is no queuing.
REQ-012 sum, cout and err SHALL hold their values from DONE until the next accepted start.
REQ-013 Operands changing after acceptance SHALL NOT affect the result in progress.
REQ-014 Boundary: when t=19, the maximum for valid digits, SHALL produce digit 9 with carry 1. When t=31, the maximum for invalid digits, SHALL produce digit 5 with carry 1.

Reset
REQ-015 rst=1 at an edge SHALL force IDLE with idx=0 and busy=0, done=0, sum=0, cout=0, err=0.
REQ-016 Reset SHALL take priority over start and over any state.
REQ-017 Reset during ADD SHALL abandon the operation with no done pulse.
REQ-018 The first start SHALL be accepted on the first edge after rst falls.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state enum (IDLE, ADD, DONE);
- NDIG=4;
- DIG_W=4;
- the BCD limit constant 9.
REQ-020 The per-digit arithmetic SHALL be a combinational sub-module bcd_digit_add with inputs x[3:0], y[3:0], ci, and outputs d[3:0], co, bad.
REQ-021 The top level SHALL instance exactly one bcd_digit_add, shared across all four digits under FSM sequencing.

Verification
REQ-022 Directed scenario: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, err=0; done exactly 5 cycles after the start edge.
REQ-023 Directed scenario: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry ripples through all digits.
REQ-024 Directed scenario: a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1, err=0.
REQ-025 Directed scenario: start pulsed during ADD and during DONE -> ignored; exactly one done pulse; result is that of the first operation.
REQ-026 Directed scenario: rst asserted in the second ADD cycle -> next cycle busy=0, sum=0, no done pulse; a fresh start then completes normally.
REQ-027 Directed scenario: a=0x000A, b=0x0005, cin=0 -> err=1, digit0=5 with carry 1, sum=0x0015; err clears on the next accepted start.
